spi_slave_fsm: RTL
==================

Name: spi_slave_fsm

Overview:
- SPI slave front end that sits directly upstream of the single-port RAM.
- Deserialises MOSI into 10-bit command words and presents each one as rx_data with a one-cycle rx_valid strobe.
- Accepts the RAM's read byte (tx_data/tx_valid) and serialises it MSB-first on MISO.
- clk is the SPI serial clock; all sampling is on its rising edge.

Parameters:
- DATA_W, 8, RAM data/address width; rx word width is DATA_W+2.
- TX_TIMEOUT, 4, cycles to wait for tx_valid after a read-data rx_valid (used only with SPI_TX_TIMEOUT_EN).

Ports:
- clk  in  1  SPI clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  slave select, active low; frames a transaction.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- rx_data  out  DATA_W+2  assembled command word {op[1:0], payload}.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  DATA_W  read byte from RAM.
- tx_valid  in  1  tx_data valid strobe from RAM.

Behaviour:
- Reset (asynchronous, active-low, immediate):
  - state=IDLE; MISO=0; rx_data=0; rx_valid=0; bit counter=0; rd_addr_done=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n sampled low -> CHK_CMD.
- CHK_CMD: samples MOSI as the select bit.
  - 0 -> WRITE.
  - 1 and rd_addr_done=0 -> READ_ADD.
  - 1 and rd_addr_done=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift in 10 MOSI bits MSB-first, one per cycle.
  - The edge sampling the 10th bit loads rx_data; rx_valid is high for exactly the next cycle.
  - Op bits are forwarded unchecked; a select/op mismatch is not corrected.
- READ_ADD completion: rd_addr_done<=1 when rx_valid fires.
- READ_DATA transmit phase:
  - After rx_valid, wait for tx_valid; latch tx_data on the edge where tx_valid=1.
  - MISO drives bit DATA_W-1 through bit 0 on the following DATA_W cycles.
  - rd_addr_done<=0 on the cycle the last bit is driven.
- After the frame's work completes: MOSI is ignored and MISO=0 until SS_n goes high.
- MISO is 0 whenever not actively shifting.
- SS_n high in any state:
  - Next state IDLE; counters cleared.
  - Partial word discarded (no rx_valid).
  - Pending or in-progress transmit aborted; rd_addr_done unchanged unless transmit completed.
- rx_valid already scheduled by a completed 10th bit still fires even if SS_n rises that cycle.
- tx_valid outside the READ_DATA wait window is ignored.
- Minimum frame: 1 cycle (IDLE->CHK_CMD) + 1 select + 10 data cycles; reads add the RAM latency plus DATA_W cycles.

Optional Feature:
- Macro: SPI_TX_TIMEOUT_EN.
- Defined:
  - A counter starts at rx_valid in READ_DATA.
  - If tx_valid has not arrived after TX_TIMEOUT cycles, load 8'hFF and shift it out as a normal read; rd_addr_done is cleared.
- Undefined: the FSM waits for tx_valid indefinitely, bounded only by SS_n.

Decomposition:
- Package spi_pkg:
  - state enum typedef.
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - DATA_W-derived width localparams, bit-counter width.
- Sub-module spi_tx_serializer: load/shift register plus counter producing MISO and a done pulse.
- The FSM, deserialiser and rd_addr_done stay in the top.

Test Plan:
- Write address: SS_n low, select 0, bits 00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle after 10th bit, MISO stays 0.
- Write data: select 0, bits 01_0011_1100 -> rx_data=10'h13C, one-cycle rx_valid; rd_addr_done unchanged.
- Read address then read data:
  - select 1, 10_0000_0111 -> rx_data=10'h207, rd_addr_done=1.
  - Next frame select 1, 11_xxxx_xxxx -> rx_valid; tx_valid with tx_data=8'hC3 two cycles later -> MISO 1,1,0,0,0,0,1,1; rd_addr_done=0.
- Abort: SS_n high after 6 data bits -> no rx_valid, state IDLE next cycle; following full write frame decodes correctly.
- Async reset mid-transmit: rst_n low while MISO shifting 8'hA5 -> MISO=0, rx_valid=0, rd_addr_done=0 immediately, without a clock edge.
- With SPI_TX_TIMEOUT_EN: read-data frame, tx_valid never asserted -> after 4 cycles MISO shifts 8'hFF; rd_addr_done=0.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, opcodes and width helpers for the SPI slave front end
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA
    } spi_state_e;

    // Progress inside a WRITE/READ_ADD/READ_DATA frame
    typedef enum logic [1:0] {
        PH_RX,
        PH_WAIT,
        PH_TX,
        PH_DONE
    } spi_phase_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int SPI_DATA_W = 8;

    function automatic int rx_width(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int bcnt_width(input int data_w);
        return $clog2(data_w + 2);
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - MSB-first MISO shifter with last-bit done pulse
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W);

    // MSB goes straight to MISO on load, so only the remaining bits are held
    logic [DATA_W-2:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;
    logic              miso_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            miso_q   <= 1'b0;
        end else if (abort_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            miso_q   <= 1'b0;
        end else if (load_i) begin
            shreg_q  <= data_i[DATA_W-2:0];
            miso_q   <= data_i[DATA_W-1];
            cnt_q    <= CNT_W'(DATA_W - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                miso_q   <= 1'b0;
                active_q <= 1'b0;
            end else begin
                miso_q  <= shreg_q[DATA_W-2];
                shreg_q <= {shreg_q[DATA_W-3:0], 1'b0};
                cnt_q   <= cnt_q - 1'b1;
            end
        end
    end

    assign miso_o = miso_q;
    // High on the edge that puts bit 0 on MISO
    assign done_o = active_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_slave_fsm.sv
// rtl/spi_slave_fsm.sv - SPI slave FSM and deserialiser; SPI_TX_TIMEOUT_EN enables read-data timeout
module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter int DATA_W     = SPI_DATA_W,
    parameter int TX_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid
);

    localparam int RX_W   = rx_width(DATA_W);
    localparam int BCNT_W = bcnt_width(DATA_W);

    spi_state_e        state_q;
    spi_phase_e        phase_q;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic [RX_W-2:0]   shift_q;
    logic [RX_W-1:0]   rx_data_q;
    logic              rx_valid_q;
    logic              rd_addr_done_q;

    logic              in_wait;
    logic              tx_timeout;
    logic              ser_load;
    logic              ser_done;
    logic [DATA_W-1:0] ser_data;

    assign in_wait  = (state_q == ST_READ_DATA) && (phase_q == PH_WAIT) && !SS_n;
    assign ser_load = in_wait && (tx_valid || tx_timeout);
    // A real RAM byte always wins over the timeout filler
    assign ser_data = tx_valid ? tx_data : '1;

`ifdef SPI_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TX_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;
    assign tx_timeout = (to_cnt_q == TO_W'(TX_TIMEOUT - 1));
`else
    assign tx_timeout = (TX_TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            phase_q        <= PH_RX;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            if (SS_n) begin
                state_q   <= ST_IDLE;
                phase_q   <= PH_RX;
                bit_cnt_q <= '0;
`ifdef SPI_TX_TIMEOUT_EN
                to_cnt_q  <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_CHK_CMD;
                    end
                    ST_CHK_CMD: begin
                        phase_q   <= PH_RX;
                        bit_cnt_q <= '0;
                        if (!MOSI)
                            state_q <= ST_WRITE;
                        else if (rd_addr_done_q)
                            state_q <= ST_READ_DATA;
                        else
                            state_q <= ST_READ_ADD;
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        case (phase_q)
                            PH_RX: begin
                                shift_q <= {shift_q[RX_W-3:0], MOSI};
                                if (bit_cnt_q == BCNT_W'(RX_W - 1)) begin
                                    rx_data_q  <= {shift_q, MOSI};
                                    rx_valid_q <= 1'b1;
                                    bit_cnt_q  <= '0;
                                    if (state_q == ST_READ_ADD)
                                        rd_addr_done_q <= 1'b1;
                                    phase_q <= (state_q == ST_READ_DATA) ? PH_WAIT : PH_DONE;
`ifdef SPI_TX_TIMEOUT_EN
                                    to_cnt_q <= '0;
`endif
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                end
                            end
                            PH_WAIT: begin
                                if (ser_load)
                                    phase_q <= PH_TX;
`ifdef SPI_TX_TIMEOUT_EN
                                else
                                    to_cnt_q <= to_cnt_q + 1'b1;
`endif
                            end
                            PH_TX: begin
                                if (ser_done) begin
                                    rd_addr_done_q <= 1'b0;
                                    phase_q        <= PH_DONE;
                                end
                            end
                            PH_DONE: begin
                            end
                            default: phase_q <= PH_DONE;
                        endcase
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ser_load),
        .abort_i (SS_n),
        .data_i  (ser_data),
        .miso_o  (MISO),
        .done_o  (ser_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
